// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: monitor-side VGA receiver; recovers x/y/de/frame_start from hs/vs/rgb and checks frame timing.
// Define VGA_DECODER_CRC_EN to add frame_crc/crc_valid (CRC-16-CCITT over the active pixels of each locked frame).
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL     = 1344,
    parameter int unsigned V_TOTAL     = 806,
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned H_ACT_START = 296,
    parameter int unsigned V_ACT_START = 34,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        de,
    output logic [3:0]  r_o,
    output logic [3:0]  g_o,
    output logic [3:0]  b_o,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err
`ifdef VGA_DECODER_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;
    localparam int unsigned GW = 4;
    localparam int unsigned PW = 12;
    localparam logic [HW-1:0] H_SAT = '1;
    localparam logic [VW-1:0] V_SAT = '1;

    typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_e;

    logic          hs_q, hs_p_q, vs_q, vs_p_q;
    logic [PW-1:0] pix_q, pix_p_q;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          vflag_q, vflag_d;
    logic          lines_ok_q, lines_ok_d;
    state_e        state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic          hs_edge, vs_edge, consume, line_ok, frame_ok;
    logic          err_d, locked_d;
    logic          act_h, act_v, de_d, fs_d;
    logic [HW-1:0] x_d;
    logic [VW-1:0] y_d;
    logic [PW-1:0] pix_d;

    // Input capture plus one history stage: edges are seen on the registered pair, colour stays aligned with hcnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q    <= !SYNC_POL;
            hs_p_q  <= !SYNC_POL;
            vs_q    <= !SYNC_POL;
            vs_p_q  <= !SYNC_POL;
            pix_q   <= '0;
            pix_p_q <= '0;
        end else begin
            hs_q    <= hs;
            hs_p_q  <= hs_q;
            vs_q    <= vs;
            vs_p_q  <= vs_q;
            pix_q   <= {r, g, b};
            pix_p_q <= pix_q;
        end
    end

    // Sync edges, counters and per-line / per-frame timing checks.
    always_comb begin
        hs_edge    = (hs_q == SYNC_POL) && (hs_p_q != SYNC_POL);
        vs_edge    = (vs_q == SYNC_POL) && (vs_p_q != SYNC_POL);
        consume    = hs_edge && (vflag_q || vs_edge);
        line_ok    = (hcnt_q == HW'(H_TOTAL - 1));
        frame_ok   = (vcnt_q == VW'(V_TOTAL - 1)) && lines_ok_q && line_ok;

        hcnt_d = hcnt_q;
        if (hs_edge)              hcnt_d = '0;
        else if (hcnt_q != H_SAT) hcnt_d = hcnt_q + HW'(1);

        vcnt_d = vcnt_q;
        if (consume)                      vcnt_d = '0;
        else if (hs_edge && vcnt_q != V_SAT) vcnt_d = vcnt_q + VW'(1);

        vflag_d = vflag_q;
        if (consume)      vflag_d = 1'b0;
        else if (vs_edge) vflag_d = 1'b1;

        lines_ok_d = lines_ok_q;
        if (consume)                 lines_ok_d = 1'b1;
        else if (hs_edge && !line_ok) lines_ok_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (consume) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (consume && frame_ok) begin
                    good_d = good_q + GW'(1);
                    if (good_d == GW'(LOCK_FRAMES)) state_d = ST_LOCKED;
                end else if (consume || (hs_edge && !line_ok)) begin
                    good_d = '0;
                end
            end
            ST_LOCKED: begin
                // hcnt saturating means hs has vanished; vcnt saturating means vs has.
                if ((hs_edge && !line_ok) || (consume && !frame_ok) ||
                    (hcnt_q == H_SAT) || (vcnt_q == V_SAT)) begin
                    err_d   = 1'b1;
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    // Output decode gated by the next lock state so de falls on the same cycle as locked.
    always_comb begin
        act_h = (32'(hcnt_q) >= H_ACT_START) && (32'(hcnt_q) < H_ACT_START + H_ACTIVE);
        act_v = (32'(vcnt_q) >= V_ACT_START) && (32'(vcnt_q) < V_ACT_START + V_ACTIVE);
        de_d  = locked_d && act_h && act_v;
        x_d   = de_d ? HW'(32'(hcnt_q) - H_ACT_START) : '0;
        y_d   = de_d ? VW'(32'(vcnt_q) - V_ACT_START) : '0;
        pix_d = de_d ? pix_p_q : '0;
        fs_d  = de_d && (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            vflag_q     <= 1'b0;
            lines_ok_q  <= 1'b0;
            state_q     <= ST_SEARCH;
            good_q      <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            r_o         <= '0;
            g_o         <= '0;
            b_o         <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            vflag_q     <= vflag_d;
            lines_ok_q  <= lines_ok_d;
            state_q     <= state_d;
            good_q      <= good_d;
            x           <= x_d;
            y           <= y_d;
            de          <= de_d;
            {r_o, g_o, b_o} <= pix_d;
            frame_start <= fs_d;
            locked      <= locked_d;
            timing_err  <= err_err_sel(err_d);
        end
    end

    function automatic logic err_err_sel(input logic e);
        return e;
    endfunction

`ifdef VGA_DECODER_CRC_EN
    logic [15:0] crc_run_q, crc_run_d, frame_crc_d;
    logic        last_px;

    function automatic logic [15:0] crc12(input logic [15:0] c, input logic [PW-1:0] d);
        logic [15:0] t;
        t = c;
        for (int i = 11; i >= 0; i--) begin
            if (t[15] ^ d[i]) t = {t[14:0], 1'b0} ^ 16'h1021;
            else              t = {t[14:0], 1'b0};
        end
        return t;
    endfunction

    // Running CRC over the output pixels; published one cycle after the last active pixel.
    always_comb begin
        crc_run_d = crc_run_q;
        if (frame_start)  crc_run_d = crc12(16'hFFFF, {r_o, g_o, b_o});
        else if (de)      crc_run_d = crc12(crc_run_q, {r_o, g_o, b_o});
        last_px     = de && (x == HW'(H_ACTIVE - 1)) && (y == VW'(V_ACTIVE - 1));
        frame_crc_d = last_px ? crc_run_d : frame_crc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_run_q <= '0;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_run_q <= crc_run_d;
            frame_crc <= frame_crc_d;
            crc_valid <= last_px;
        end
    end
`endif

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Monitor-side end of the VGA output interface: consumes the hs/vs/r/g/b stream produced by the game's VGA pipeline.
- Recovers pixel coordinates, data-enable and frame markers, and checks the stream against nominal XGA timing (1024x768, 65 MHz pixel clock).
- Used on-chip as a self-test/loopback checker and as the golden monitor in the top-level benches.
- Runs on the pixel clock alongside the VGA generator.

Parameters:
- H_TOTAL, 1344, pixel clocks per line.
- V_TOTAL, 806, lines per frame.
- H_ACTIVE, 1024, active pixels per line.
- V_ACTIVE, 768, active lines per frame.
- H_ACT_START, 296, hcnt value of first active pixel; hcnt=0 on the hs assertion cycle.
- V_ACT_START, 34, vcnt value of first active line; vcnt=0 on the first line after vs assertion.
- SYNC_POL, 0, sync assertion level (0 = active-low, XGA).
- LOCK_FRAMES, 2, consecutive clean frames required to lock (1..15).

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous active-high reset
- hs  in  1  horizontal sync from the VGA pipeline
- vs  in  1  vertical sync from the VGA pipeline
- r  in  4  red
- g  in  4  green
- b  in  4  blue
- x  out  11  recovered column, 0..1023 while de=1, else 0
- y  out  10  recovered row, 0..767 while de=1, else 0
- de  out  1  active-pixel strobe
- r_o, g_o, b_o  out  4 each  colour, aligned with de; forced 0 when de=0
- frame_start  out  1  1-cycle pulse with pixel (0,0)
- locked  out  1  timing lock indicator
- timing_err  out  1  1-cycle pulse on a timing violation while locked

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset: every output is 0, hcnt=vcnt=0, FSM=SEARCH, good-frame counter=0.
- Input stage: hs/vs/r/g/b registered once. Assertion edges are detected on the registered values, using SYNC_POL.
- Latency: x/y/de/colour/frame_start appear 2 clocks after the input sample.
- hcnt (11 bit): loads 0 on an hs edge, else increments; saturates at 2047.
- Line check: on an hs edge, line_ok = (hcnt == H_TOTAL-1).
- vcnt (10 bit): on a vs edge, arm a flag. At the next hs edge vcnt loads 0 and the flag clears. Otherwise each hs edge increments vcnt, saturating at 1023.
- Simultaneous hs and vs edges: the flag is armed and consumed in the same cycle, so vcnt=0.
- Frame check: on an hs edge that consumes the armed flag, frame_ok = (vcnt == V_TOTAL-1) and every line since the previous frame had line_ok.
- de = locked and H_ACT_START <= hcnt < H_ACT_START+H_ACTIVE and V_ACT_START <= vcnt < V_ACT_START+V_ACTIVE.
- Coordinates: x = hcnt-H_ACT_START, y = vcnt-V_ACT_START (widths truncated).
- frame_start = de and x==0 and y==0.
- FSM states:
  - SEARCH: wait for the first vs-anchored line start (flag consumed) -> ACQUIRE, good=0.
  - ACQUIRE: at each frame boundary, frame_ok increments good, else good=0. When good==LOCK_FRAMES -> LOCKED, locked=1. Any hs edge with !line_ok sets good=0 (no err pulse).
  - LOCKED: an hs edge with !line_ok, a frame boundary with !frame_ok, or hcnt reaching 2047 (hs lost) -> timing_err pulses 1 cycle, locked=0, FSM=SEARCH. de drops the same cycle locked drops.
  - Saturation: vcnt at 1023 in LOCKED is also a violation.
- rst mid-frame: immediate return to the reset state. No err pulse; relock requires the full SEARCH/ACQUIRE sequence.

Optional Feature:
- Macro: VGA_DECODER_CRC_EN.
- When defined, two extra ports are added:
  - frame_crc out 16
  - crc_valid out 1
- CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over the 12-bit {r_o,g_o,b_o} of every de=1 pixel. Reinitialised at frame_start, which itself is included.
- After the last active pixel (x=1023, y=767), frame_crc is updated the next cycle and crc_valid pulses 1 cycle. frame_crc holds its value until the next frame's update.
- No update while unlocked; reset clears both outputs.
- Without the macro: the ports and logic are absent, and other behaviour is identical.

Test Plan:
- Reset: hold rst 5 cycles with toggling inputs -> all outputs 0; locked stays 0 until 2 clean frames complete.
- Nominal lock: XGA model generator drives 3 frames -> locked rises at the end of frame 2. In frame 3: exactly 786432 de cycles; first de has x=0, y=0 and frame_start=1; last de has x=1023, y=767.
- Short line: one line of 1343 clocks in locked state -> timing_err pulses once at that hs edge, locked=0, de=0. Relock after 2 further clean frames.
- Lost hs: hold hs deasserted while locked -> at hcnt=2047, timing_err pulses and locked=0.
- Mid-frame reset: rst for 1 cycle at y=400 -> outputs 0 next cycle, no timing_err, relock after 2 clean frames.
- CRC (macro on): two identical frames r=x[3:0], g=y[3:0], b=0 -> equal frame_crc, crc_valid once per frame. Flipping pixel (5,7) blue to 1 -> frame_crc differs.
